// File: rtl/instruction_fetch.sv
// Instruction fetch stage: single-outstanding memory request engine feeding a
// two-entry {instr, pc, pc4} queue toward decode, with flush and misalignment handling.
module instruction_fetch #(
    parameter int INSTR_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [63:0]        PC,
    input  logic [63:0]        PC4,
    input  logic               fetch_en,
    output logic               pc_load,
    output logic               imem_req,
    output logic [63:0]        imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               flush,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [63:0]        ifid_pc,
    output logic [63:0]        ifid_pc4,
    output logic               misalign_err,
    output logic [31:0]        fetch_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          occ_q, occ_d;
    logic                head_q, head_d;
    logic                misalign_err_q, misalign_err_d;
    logic [31:0]         fetch_cnt_q, fetch_cnt_d;

    logic [INSTR_W-1:0]  instr_q [2];
    logic [INSTR_W-1:0]  instr_d [2];
    logic [63:0]         pc_q    [2];
    logic [63:0]         pc_d    [2];
    logic [63:0]         pc4_q   [2];
    logic [63:0]         pc4_d   [2];
    logic [63:0]         tag_pc_q, tag_pc_d;
    logic [63:0]         tag_pc4_q, tag_pc4_d;

    logic                aligned;
    logic                issue_ok;
    logic                accept;
    logic                push;
    logic                pop;
    logic                wr_idx;

    // Request/handshake decode; reset is folded in so imem_req drops asynchronously.
    always_comb begin
        aligned  = (PC[1:0] == 2'b00);
        issue_ok = fetch_en & ~flush & (state_q == S_IDLE) & (occ_q != 2'd2) & ~misalign_err_q;
        imem_req = reset & issue_ok & aligned;
        accept   = imem_req & imem_ready;
        push     = (state_q == S_WAIT) & imem_rvalid & ~flush;
        pop      = (occ_q != 2'd0) & ~stall & ~flush;
        wr_idx   = head_q ^ occ_q[0];
    end

    assign pc_load   = accept;
    assign imem_addr = PC;

    // Next-state for the fetch FSM; flush drops whatever response is still owed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_IDLE;
                end else if (flush) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (imem_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        occ_d          = occ_q;
        head_d         = head_q;
        misalign_err_d = misalign_err_q;
        fetch_cnt_d    = fetch_cnt_q;

        if (flush) begin
            occ_d          = 2'd0;
            misalign_err_d = 1'b0;
        end else begin
            if (push && !pop) begin
                occ_d = occ_q + 2'd1;
            end else if (pop && !push) begin
                occ_d = occ_q - 2'd1;
            end
            if (pop) begin
                head_d      = ~head_q;
                fetch_cnt_d = fetch_cnt_q + {31'd0, pop};
            end
            if (issue_ok && !aligned) begin
                misalign_err_d = 1'b1;
            end
        end
    end

    // Queue payload and request tag; slot contents are only observed while occupied.
    always_comb begin
        instr_d   = instr_q;
        pc_d      = pc_q;
        pc4_d     = pc4_q;
        tag_pc_d  = tag_pc_q;
        tag_pc4_d = tag_pc4_q;
        if (accept) begin
            tag_pc_d  = PC;
            tag_pc4_d = PC4;
        end
        if (push) begin
            instr_d[wr_idx] = imem_rdata;
            pc_d[wr_idx]    = tag_pc_q;
            pc4_d[wr_idx]   = tag_pc4_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            occ_q          <= 2'd0;
            head_q         <= 1'b0;
            misalign_err_q <= 1'b0;
            fetch_cnt_q    <= 32'd0;
        end else begin
            state_q        <= state_d;
            occ_q          <= occ_d;
            head_q         <= head_d;
            misalign_err_q <= misalign_err_d;
            fetch_cnt_q    <= fetch_cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        instr_q   <= instr_d;
        pc_q      <= pc_d;
        pc4_q     <= pc4_d;
        tag_pc_q  <= tag_pc_d;
        tag_pc4_q <= tag_pc4_d;
    end

    // Head fields read as zero whenever the queue is empty, including during reset.
    always_comb begin
        ifid_valid   = (occ_q != 2'd0);
        ifid_instr   = '0;
        ifid_pc      = '0;
        ifid_pc4     = '0;
        if (ifid_valid) begin
            ifid_instr = instr_q[head_q];
            ifid_pc    = pc_q[head_q];
            ifid_pc4   = pc4_q[head_q];
        end
        misalign_err = misalign_err_q;
        fetch_cnt    = fetch_cnt_q;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter INSTR_W, default 32: instruction word width.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 PC  input  64  current program counter value.
REQ-005 PC4  input  64  program counter + 4.
REQ-006 fetch_en  input  1  fetch permitted when high.
REQ-007 pc_load  output  1  advance program counter; high in cycle a request is accepted.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  64  request address; equals PC.
REQ-010 imem_ready  input  1  memory accepts request when imem_req & imem_ready.
REQ-011 imem_rvalid  input  1  response valid; never in the same cycle as its own acceptance.
REQ-012 imem_rdata  input  INSTR_W  response instruction word.
REQ-013 stall  input  1  decode not ready to take head entry.
REQ-014 flush  input  1  discard all fetched and in-flight instructions.
REQ-015 ifid_valid  output  1  head entry valid.
REQ-016 ifid_instr / ifid_pc / ifid_pc4  output  INSTR_W / 64 / 64  head entry fields.
REQ-017 misalign_err  output  1  sticky: fetch blocked on PC[1:0] != 0.
REQ-018 fetch_cnt  output  32  count of instructions delivered to decode.

Function
REQ-019 Block SHALL hold a 2-entry FIFO of {instr, pc, pc4}; occ in 0..2; ifid_* = head; ifid_valid = (occ != 0).
REQ-020 FSM states: IDLE (nothing in flight), WAIT (one request in flight), DISCARD (in-flight response to be dropped).
REQ-021 imem_req SHALL be combinational: reset high & fetch_en & !flush & state==IDLE & occ<2 & PC[1:0]==0 & !misalign_err.
REQ-022 At most one request outstanding at any time.
REQ-023 Acceptance (imem_req & imem_ready): pc_load=1 same cycle; PC and PC4 latched as tag; IDLE->WAIT.
REQ-024 WAIT & imem_rvalid & !flush: push {imem_rdata, tag pc, tag pc4}; WAIT->IDLE.
REQ-025 Pop when ifid_valid & !stall; push and pop same cycle leave occ unchanged, head advances correctly.
REQ-026 Push never occurs at occ==2 (guaranteed by REQ-021).
REQ-027 flush SHALL, next edge: occ=0, ifid_valid=0; WAIT without rvalid -> DISCARD; WAIT with rvalid -> IDLE, response dropped; IDLE stays IDLE.
REQ-028 DISCARD: no requests; imem_rvalid drops response, -> IDLE; flush in DISCARD keeps DISCARD.
REQ-029 flush SHALL win over push and pop in the same cycle; no pop counted.
REQ-030 PC[1:0] != 0 when request would otherwise issue: misalign_err set next edge, no request, no pc_load; cleared only by flush or reset.
REQ-031 fetch_cnt SHALL increment by 1 per pop, wrap 0xFFFFFFFF->0.
REQ-032 imem_rvalid in IDLE SHALL be ignored.

Reset
REQ-033 reset low SHALL immediately force: state IDLE, occ 0, ifid_valid 0, ifid_instr/pc/pc4 0, misalign_err 0, fetch_cnt 0, imem_req 0, pc_load 0.
REQ-034 reset asserted mid-request: in-flight response after reset release arrives in IDLE and is ignored.
REQ-035 First request SHALL be possible in the first cycle after reset goes high.

Verification
REQ-036 PC=0x0, imem_ready=1, rvalid 1 cycle after accept, rdata=0x8B020020, stall=0 -> pc_load 1 cycle; next cycle ifid_valid=1, ifid_pc=0x0, ifid_pc4=0x4, ifid_instr=0x8B020020; fetch_cnt=1.
REQ-037 stall=1 held, three fetches attempted -> occ reaches 2, imem_req stays 0 afterward; release stall -> entries in order, pc 0x0 then 0x4.
REQ-038 flush in WAIT cycle before rvalid -> DISCARD; rvalid dropped; ifid_valid 0; next request issues from new PC (e.g. 0x100).
REQ-039 flush and rvalid same cycle with occ=1 and stall=0 -> occ 0, no push, fetch_cnt unchanged, state IDLE.
REQ-040 PC=0x102 with fetch_en=1 -> imem_req 0, misalign_err 1 next cycle; flush -> misalign_err 0.
REQ-041 reset low during WAIT -> all outputs 0 immediately; late rvalid after release ignored, ifid_valid stays 0.
